// File: rtl/f3m_inv_sched_pkg.sv
// Definitions shared by the f3m operation schedulers: field width, zero element, FSM states.
package f3m_inv_sched_pkg;

  localparam int M   = 97;
  localparam int LEN = 2 * M;

  localparam logic [LEN-1:0] F3M_ZERO = {LEN{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_t;

  function automatic logic f3m_is_zero(input logic [LEN-1:0] v);
    return v == F3M_ZERO;
  endfunction

endpackage

// File: rtl/f3m_inv_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, ascending with wrap.
// Zero latency; the caller registers the winner.
module f3m_inv_sched_rr_arbiter
  import f3m_inv_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            vld_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f3m_inv_sched.sv
// Round-robin time-sharing of one external GF(3^m) inverter; zero operands bypass it with err.
// Latency INV_CYCLES+4 clocks (3 for a zero operand); requests are only sampled in IDLE.
module f3m_inv_sched
  import f3m_inv_sched_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int INV_CYCLES = 200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*LEN-1:0] operand,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic [LEN-1:0]      result,
  output logic                err,
  output logic                busy,
  output logic [LEN-1:0]      inv_a,
  output logic                inv_start,
  input  logic [LEN-1:0]      inv_c
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(INV_CYCLES + 1);

  sched_state_t    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LEN-1:0]  inv_a_q, inv_a_d;
  logic [LEN-1:0]  result_q, result_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_vld;
  logic [LEN-1:0]  sel_op;

  f3m_inv_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  assign sel_op = operand[int'(idx_q)*LEN +: LEN];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    grant_d  = grant_q;
    done_d   = '0;
    cnt_d    = cnt_q;
    inv_a_d  = inv_a_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          idx_d   = arb_idx;
          grant_d = arb_gnt;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        inv_a_d = sel_op;
        zero_d  = f3m_is_zero(sel_op);
        state_d = f3m_is_zero(sel_op) ? ST_DONE : ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(INV_CYCLES - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // Zero operands never reach the inverter, so inv_c is meaningless for them.
        result_d = zero_q ? F3M_ZERO : inv_c;
        done_d   = grant_q;
        err_d    = zero_q;
        grant_d  = '0;
        ptr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      cnt_q    <= '0;
      inv_a_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      inv_a_q  <= inv_a_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign inv_a     = inv_a_q;
  assign inv_start = (state_q == ST_START);

endmodule

// File: tb/tb_f3m_inv_sched.sv
// Randomised bench for f3m_inv_sched with a stand-in inverter of the same fixed latency.
module tb_f3m_inv_sched;
  import f3m_inv_sched_pkg::*;

  localparam int NREQ       = 4;
  localparam int INV_CYCLES = 200;
  localparam logic [LEN-1:0] MASK = {M{2'b01}};

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req   = '0;
  logic [NREQ*LEN-1:0] operand;
  logic [NREQ-1:0]     grant, done;
  logic [LEN-1:0]      result, inv_a, inv_c;
  logic                err, busy, inv_start;
  logic [LEN-1:0]      opnd [NREQ];

  int n_chk   = 0;
  int n_err   = 0;
  int n_start = 0;
  int bad_gnt = 0;
  int ptr_m   = 0;
  logic [LEN-1:0] last_res = '0;

  logic [LEN-1:0] m_a   = '0;
  int             m_cnt = 0;

  always #5 clk = ~clk;

  f3m_inv_sched #(
    .NREQ       (NREQ),
    .INV_CYCLES (INV_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .operand   (operand),
    .grant     (grant),
    .done      (done),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .inv_a     (inv_a),
    .inv_start (inv_start),
    .inv_c     (inv_c)
  );

  always_comb begin
    operand = '0;
    for (int i = 0; i < NREQ; i++) operand[i*LEN +: LEN] = opnd[i];
  end

  // Any bijection works as the "inverse"; before the latency expires the output is deliberately wrong.
  function automatic logic [LEN-1:0] finv(input logic [LEN-1:0] a);
    return {a[LEN-4:0], a[LEN-1:LEN-3]} ^ MASK;
  endfunction

  always @(posedge clk) begin
    if (inv_start) begin
      m_a   <= inv_a;
      m_cnt <= 0;
    end else if (m_cnt < INV_CYCLES) begin
      m_cnt <= m_cnt + 1;
    end
  end
  assign inv_c = (m_cnt >= INV_CYCLES) ? finv(m_a) : ~finv(m_a);

  always @(negedge clk) begin
    if (inv_start === 1'b1) n_start++;
    if (!$onehot0(grant)) bad_gnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LEN-1:0] rand_op(input bit allow_zero);
    logic [223:0] t;
    if (allow_zero && $urandom_range(0, 3) == 0) return '0;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    if (t[LEN-1:0] == '0) t[0] = 1'b1;
    return t[LEN-1:0];
  endfunction

  // Reference arbitration: first requester at or after the pointer, ascending with wrap.
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // Called on a negedge with req already set and the DUT idle; returns on the done cycle.
  task automatic serve(input bit drop_mid, input bit add_mid, output int w);
    logic [LEN-1:0] exp_res;
    bit             z;
    int             lat, s0;
    w       = pick(req, ptr_m);
    z       = (opnd[w] == '0);
    exp_res = z ? '0 : finv(opnd[w]);
    s0      = n_start;
    @(negedge clk);
    lat = 1;
    chk("grant", grant, NREQ'(1) << w);
    chk("busy_on", busy, 1'b1);
    chk("res_hold", result, last_res);
    chk("idle_done_err", {done, err}, '0);
    while (done == '0 && lat < INV_CYCLES + 20) begin
      if (lat == 50 && drop_mid) req[w] = 1'b0;
      if (lat == 60 && add_mid) begin
        for (int j = 0; j < NREQ; j++) begin
          if (j != w && !req[j] && $urandom_range(0, 1) == 1) begin
            opnd[j] = rand_op(1'b1);
            req[j]  = 1'b1;
          end
        end
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, z ? 3 : INV_CYCLES + 4);
    chk("done", done, NREQ'(1) << w);
    chk("err", err, z);
    chk("result", result, exp_res);
    chk("grant_drop", grant, '0);
    chk("busy_off", busy, 1'b0);
    chk("start_pulses", n_start - s0, z ? 0 : 1);
    ptr_m    = (w + 1) % NREQ;
    last_res = exp_res;
    req[w]   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, s0;
    for (int i = 0; i < NREQ; i++) opnd[i] = '0;

    #2 reset = 1'b0;
    #1;
    chk("rst_ctrl", {grant, done, err, busy, inv_start}, '0);
    chk("rst_result", result, '0);
    chk("rst_inv_a", inv_a, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // All four requesting from reset: order 0,1,2,3 then 0 again.
    for (int i = 0; i < NREQ; i++) opnd[i] = rand_op(1'b0);
    req = '1;
    for (int k = 0; k < 5; k++) begin
      serve(1'b0, 1'b0, w);
      opnd[w] = rand_op(1'b0);
      req[w]  = 1'b1;
    end
    req = '0;

    // Single request with a small fixed operand.
    opnd[0] = 194'b10_01_01_10_01_00;
    req     = 4'b0001;
    serve(1'b0, 1'b0, w);

    // Zero operand bypasses the inverter.
    opnd[2] = '0;
    req     = 4'b0100;
    serve(1'b0, 1'b0, w);

    // Reset in the middle of WAIT abandons the operation.
    opnd[1] = rand_op(1'b0);
    req     = 4'b0010;
    s0      = n_start;
    repeat (103) @(negedge clk);
    chk("wait_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("midrst_ctrl", {grant, done, err, busy, inv_start}, '0);
    chk("midrst_result", result, '0);
    chk("midrst_inv_a", inv_a, '0);
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("midrst_no_done", {done, n_start - s0}, 1);
    ptr_m    = 0;
    last_res = '0;
    opnd[2]  = rand_op(1'b0);
    opnd[3]  = rand_op(1'b0);
    req      = 4'b1100;
    serve(1'b0, 1'b0, w);
    serve(1'b0, 1'b0, w);

    // Wrap-around: serve 3 alone, then 0 must win over 3.
    opnd[3] = rand_op(1'b0);
    req     = 4'b1000;
    serve(1'b0, 1'b0, w);
    opnd[0] = rand_op(1'b0);
    opnd[3] = rand_op(1'b0);
    req     = 4'b1001;
    serve(1'b0, 1'b0, w);
    serve(1'b0, 1'b0, w);

    // Served requester drops req mid-operation.
    for (int i = 0; i < 3; i++) opnd[i] = rand_op(1'b0);
    req = 4'b0111;
    serve(1'b1, 1'b0, w);
    serve(1'b1, 1'b0, w);
    req = '0;

    for (int it = 0; it < 24; it++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!req[j] && $urandom_range(0, 2) != 0) begin
          opnd[j] = rand_op(1'b1);
          req[j]  = 1'b1;
        end
      end
      if (req == '0) begin
        opnd[it % NREQ] = rand_op(1'b1);
        req[it % NREQ]  = 1'b1;
      end
      serve($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, w);
    end

    chk("grant_onehot", bad_gnt, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
